// File: rtl/dw_pipe_shifter.sv
// dw_pipe_shifter: pipelined shift/rotate unit (LSL/LSR/ASR/ROL/ROR, signed control) with valid/ready handshake.
module dw_pipe_shifter #(
    parameter int A_width  = 49,
    parameter int SH_width = 6,
    parameter int STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [A_width-1:0]  A,
    input  logic [SH_width-1:0] SH,
    input  logic                SH_TC,
    input  logic [2:0]          MODE,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [A_width-1:0]  B
);
    localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROL = 3'd3, ROR = 3'd4;
    localparam int BASE = SH_width / STAGES;
    localparam int REM  = SH_width % STAGES;

    // earlier registers absorb the remainder of the log2 steps
    function automatic int stage_of(input int i);
        return i < REM * (BASE + 1) ? i / (BASE + 1) : REM + (i - REM * (BASE + 1)) / BASE;
    endfunction

    function automatic logic [A_width-1:0] step(input logic [A_width-1:0] d, input logic [2:0] m, input int s);
        logic [A_width-1:0] asr, rol, ror;
        int r;
        r = s % A_width;
        asr = $signed(d) >>> s;
        rol = (d << r) | (d >> (A_width - r));
        ror = (d >> r) | (d << (A_width - r));
        return m == LSL ? d << s : m == LSR ? d >> s : m == ASR ? asr : m == ROL ? rol : m == ROR ? ror : d;
    endfunction

    function automatic logic [A_width-1:0] run(input logic [A_width-1:0] d, input logic [SH_width-1:0] a,
                                               input logic [2:0] m, input int k);
        logic [A_width-1:0] r;
        r = d;
        for (int i = 0; i < SH_width; i++)
            if (stage_of(i) == k && a[i]) r = step(r, m, 1 << i);
        return r;
    endfunction

    logic                neg;
    logic [SH_width-1:0] amt, amt0;
    logic [2:0]          mode0;
    logic                adv;
    logic [STAGES-1:0]   v_q;
    logic [A_width-1:0]  d_in [STAGES];
    logic [A_width-1:0]  d_q  [STAGES];
    logic [SH_width-1:0] a_in [STAGES];
    logic [SH_width-1:0] a_q  [STAGES];
    logic [2:0]          m_in [STAGES];
    logic [2:0]          m_q  [STAGES];

    // negative control flips direction; rotate amounts reduced here so later steps never exceed A_width
    always_comb begin
        neg   = SH_TC && SH[SH_width-1];
        amt   = neg ? -SH : SH;
        mode0 = !neg ? MODE : MODE == LSL ? LSR : (MODE == LSR || MODE == ASR) ? LSL :
                MODE == ROL ? ROR : MODE == ROR ? ROL : MODE;
        amt0  = (mode0 == ROL || mode0 == ROR) ? SH_width'(32'(amt) % A_width) : amt;
    end

    assign d_in[0] = A;
    assign a_in[0] = amt0;
    assign m_in[0] = mode0;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign d_in[k] = d_q[k-1];
        assign a_in[k] = a_q[k-1];
        assign m_in[k] = m_q[k-1];
    end

    assign adv       = !v_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign B         = d_q[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                a_q[k] <= '0;
                m_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= STAGES'({v_q, in_valid});
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= run(d_in[k], a_in[k], m_in[k], k);
                a_q[k] <= a_in[k];
                m_q[k] <= m_in[k];
            end
        end
    end
endmodule

// File: tb/tb_dw_pipe_shifter.sv
// tb_dw_pipe_shifter: directed 8-bit checks plus a randomised 49-bit stream against a bitwise reference.
module tb_dw_pipe_shifter;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, tc8;
    logic [7:0] a8, b8;
    logic [3:0] sh8;
    logic [2:0] md8;
    logic        iv49, ir49, ov49, or49, tc49;
    logic [48:0] a49, b49;
    logic [5:0]  sh49;
    logic [2:0]  md49;

    dw_pipe_shifter #(.A_width(8), .SH_width(4), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .SH(sh8), .SH_TC(tc8),
        .MODE(md8), .out_valid(ov8), .out_ready(or8), .B(b8));

    dw_pipe_shifter dut49 (
        .clk(clk), .rst(rst), .in_valid(iv49), .in_ready(ir49), .A(a49), .SH(sh49), .SH_TC(tc49),
        .MODE(md49), .out_valid(ov49), .out_ready(or49), .B(b49));

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic one8(input string tag, input logic [7:0] a, input logic [3:0] sh, input logic tc,
                        input logic [2:0] m, input logic [7:0] exp);
        @(negedge clk);
        a8 = a; sh8 = sh; tc8 = tc; md8 = m; iv8 = 1; or8 = 1;
        @(negedge clk);
        iv8 = 0;
        chk({tag, "_early"}, 64'(ov8), 0);
        @(negedge clk);
        chk({tag, "_vld"}, 64'(ov8), 1);
        chk(tag, 64'(b8), 64'(exp));
    endtask

    function automatic logic [48:0] ref49(input logic [48:0] a, input logic [5:0] sh, input logic tc,
                                          input logic [2:0] m);
        logic [48:0] r;
        logic [2:0]  mm;
        logic        neg;
        int          amt, k;
        neg = tc && sh[5];
        amt = neg ? 64 - int'(sh) : int'(sh);
        mm = m;
        if (neg)
            case (m)
                3'd0:       mm = 3'd1;
                3'd1, 3'd2: mm = 3'd0;
                3'd3:       mm = 3'd4;
                3'd4:       mm = 3'd3;
                default:    mm = m;
            endcase
        k = amt % 49;
        for (int j = 0; j < 49; j++)
            case (mm)
                3'd0:    r[j] = j >= amt ? a[j-amt] : 1'b0;
                3'd1:    r[j] = j + amt < 49 ? a[j+amt] : 1'b0;
                3'd2:    r[j] = j + amt < 49 ? a[j+amt] : a[48];
                3'd3:    r[j] = a[(j - k + 49) % 49];
                3'd4:    r[j] = a[(j + k) % 49];
                default: r[j] = a[j];
            endcase
        return r;
    endfunction

    logic [7:0] bp_in  [6] = '{8'h01, 8'h80, 8'h96, 8'h5A, 8'hC3, 8'h7F};
    logic [7:0] bp_exp [6] = '{8'h02, 8'h00, 8'h2C, 8'hB4, 8'h86, 8'hFE};

    initial begin
        int sent, got, stray, acc, rcv;
        logic held, pend;
        logic [7:0] hb;
        logic [48:0] q[$];
        iv8 = 0; or8 = 1; a8 = 0; sh8 = 0; tc8 = 0; md8 = 0;
        iv49 = 0; or49 = 1; a49 = 0; sh49 = 0; tc49 = 0; md49 = 0;
        #12;
        chk("rst_ov8", 64'(ov8), 0);
        chk("rst_b8", 64'(b8), 0);
        chk("rst_ov49", 64'(ov49), 0);
        chk("rst_b49", 64'(b49), 0);
        @(negedge clk);
        rst = 0;
        #1 chk("rst_rdy", 64'(ir8), 1);

        one8("lsl", 8'h96, 4'd3, 0, 3'd0, 8'hB0);
        one8("lsr", 8'h96, 4'd3, 0, 3'd1, 8'h12);
        one8("asr", 8'h96, 4'd3, 0, 3'd2, 8'hF2);
        one8("rol", 8'h96, 4'd3, 0, 3'd3, 8'hB4);
        one8("ror", 8'h96, 4'd3, 0, 3'd4, 8'hD2);
        one8("neg_rol", 8'h96, 4'hE, 1, 3'd3, 8'hA5);
        one8("neg_asr", 8'h96, 4'hE, 1, 3'd2, 8'h58);
        one8("u14_rol", 8'h96, 4'hE, 0, 3'd3, 8'hA5);
        one8("neg_lsl", 8'h96, 4'hC, 1, 3'd0, 8'h09);
        one8("ovr_lsl", 8'h96, 4'd9, 0, 3'd0, 8'h00);
        one8("ovr_lsr", 8'hFF, 4'd15, 0, 3'd1, 8'h00);
        one8("ovr_asr", 8'h80, 4'd9, 0, 3'd2, 8'hFF);
        one8("ovr_ror", 8'h01, 4'd9, 0, 3'd4, 8'h80);
        one8("rol8", 8'h5A, 4'd8, 0, 3'd3, 8'h5A);
        one8("amt0", 8'h96, 4'd0, 0, 3'd4, 8'h96);
        one8("pass", 8'h96, 4'd3, 1, 3'd5, 8'h96);

        sent = 0; got = 0; held = 0; hb = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            if (held) chk($sformatf("bp_hold%0d", c), 64'(b8), 64'(hb));
            or8 = !(c >= 3 && c <= 5);
            iv8 = sent < 6;
            a8 = bp_in[sent < 6 ? sent : 5]; sh8 = 4'd1; tc8 = 0; md8 = 3'd0;
            #1;
            held = ov8 && !or8;
            hb = b8;
            if (held) chk("bp_stall_rdy", 64'(ir8), 0);
            if (ov8 && or8) begin
                chk($sformatf("bp_out%0d", got), 64'(b8), 64'(bp_exp[got]));
                got++;
            end
            if (iv8 && ir8) sent++;
        end
        chk("bp_count", 64'(got), 6);

        @(negedge clk);
        or8 = 0; iv8 = 1; a8 = 8'h96; sh8 = 4'd3; tc8 = 0; md8 = 3'd0;
        @(negedge clk);
        a8 = 8'h5A;
        @(negedge clk);
        iv8 = 0;
        chk("pre_rst_vld", 64'(ov8), 1);
        #2 rst = 1;
        #1;
        chk("async_rst_ov", 64'(ov8), 0);
        chk("async_rst_b", 64'(b8), 0);
        @(negedge clk);
        rst = 0; or8 = 1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov8) stray++;
        end
        chk("rst_stray", 64'(stray), 0);

        acc = 0; rcv = 0; pend = 0;
        for (int c = 0; c < 60000 && rcv < 10000; c++) begin
            @(negedge clk);
            if (!pend && acc < 10000 && $urandom_range(0, 7) != 0) begin
                a49  = 49'({$urandom, $urandom});
                sh49 = $urandom_range(0, 7) == 0 ? 6'h20 : 6'($urandom);
                tc49 = 1'($urandom_range(0, 1));
                md49 = 3'($urandom);
                pend = 1;
            end
            iv49 = pend;
            or49 = $urandom_range(0, 3) != 0;
            #1;
            if (ov49 && or49) begin
                if (q.size() > 0) chk($sformatf("rnd%0d", rcv), 64'(b49), 64'(q.pop_front()));
                else chk($sformatf("rnd_extra%0d", rcv), 64'(ov49), 0);
                rcv++;
            end
            if (iv49 && ir49) begin
                q.push_back(ref49(a49, sh49, tc49, md49));
                pend = 0;
                acc++;
            end
        end
        iv49 = 0;
        chk("rnd_count", 64'(rcv), 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dw_pipe_shifter.md
Name: dw_pipe_shifter

Overview:
- Parametrised, pipelined successor to the team's combinational left barrel rotator.
- Supports five modes: logical shift left/right, arithmetic shift right, rotate left/right.
- Signed (two's-complement) shift control reverses direction; rotate amounts reduce modulo A_width.
- Registered datapath with a valid/ready handshake, for use inside DSP datapaths (normalisation, CORDIC alignment) running at full clock rate.

Parameters:
A_width, 49, data word length (>=2)
SH_width, 6, shift-control word length (>=1)
STAGES, 2, pipeline register stages = latency in cycles (1..SH_width)

Ports:
clk  in  1  clock, all registers rising-edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
A  in  A_width  input data
SH  in  SH_width  shift amount
SH_TC  in  1  0: SH unsigned; 1: SH two's complement
MODE  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 pass-through
out_valid  out  1  B valid
out_ready  in  1  downstream accepts B
B  out  A_width  result

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-high (rst).
- Reset: all stage valid bits 0, all data/control registers 0. Hence out_valid=0, B=0, and in_ready=1 once rst deasserts.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready: a global stall freezes every stage while the last stage holds an unaccepted word.
  - Bubbles do not collapse.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput: 1 word/cycle.
- While stalled, B and out_valid hold stable; the A, SH and MODE inputs are ignored.
- Direction decode (stage 0):
  - neg = SH_TC && SH[SH_width-1].
  - amt = neg ? (~SH+1) : SH, taken as unsigned SH_width bits.
  - Most-negative SH yields amt = 2^(SH_width-1).
  - If neg: LSL<->LSR, ASR->LSL, ROL<->ROR. Pass-through is unaffected.
- Shift modes (after decode):
  - amt >= A_width gives B = 0 for LSL/LSR.
  - amt >= A_width gives B = {A_width{A[MSB]}} for ASR.
  - amt = 0 gives B = A.
- Rotate modes: effective amount = amt mod A_width.
  - Computed with no iterative-loop construct; a constant-divisor reduction is acceptable.
  - When A_width is a power of two, the reduction is the low bits of amt.
  - Rotate by A_width*k gives B = A.
- Datapath structure:
  - log2 stages (shift by 2^i, i = 0..SH_width-1), plus a final zero/sign-fill select.
  - Distribute the log2 stages across STAGES registers as evenly as possible, earlier stages taking the remainder.
  - Mode, fill bit and any over-range flag travel with the data.
- Pass-through modes (101-111): B = A with the same latency.
- Reset mid-operation: all in-flight words are discarded and none are emitted after reset.
- Simultaneous output accept and input accept on a full pipeline: the pipeline advances by one word with no loss and no duplication.

Test Plan:
- Basic latency/modes (A_width=8, SH_width=4, STAGES=2): A=0x96, SH=3, SH_TC=0.
  - LSL -> 0xB0; LSR -> 0x12; ASR -> 0xF2; ROL -> 0xB4; ROR -> 0xD2.
  - Each result appears exactly 2 cycles after its transfer.
- Negative control: A=0x96, SH=4'hE (-2), SH_TC=1.
  - ROL -> 0xA5 (rotate right 2); ASR -> 0x58 (shift left 2).
  - The same SH with SH_TC=0 in ROL (amt 14, mod 8 = 6) -> 0xA5.
- Over-range (A_width=8, SH_width=4): SH=9.
  - LSL -> 0x00; ASR on A=0x80 -> 0xFF; ROR on A=0x01 -> 0x80.
  - Extra case: SH=8, ROL, A=0x5A -> 0x5A.
- Backpressure: stream 6 words back-to-back with out_ready low for cycles 3-5.
  - in_ready drops while the output is held; B stays stable.
  - All 6 results arrive in order, with no drops or duplicates.
- Reset mid-flight: assert rst with 2 words in the pipeline.
  - out_valid=0 and B=0 immediately (asynchronously).
  - After release, no stale word is ever emitted.
- Default parameters (49/6/2): randomised 10k words with random out_ready, checked against a reference model for all MODE/SH_TC combinations, including SH=6'h20 with SH_TC=1.
